// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IM   = 2'd1,
    OWN_DM   = 2'd2
  } mem_owner_t;

  typedef enum logic {
    ARB_DM_PRIO = 1'b0,
    ARB_IM_PRIO = 1'b1
  } arb_state_t;

  // Wide enough for the largest legal IM_MAX_WAIT (15).
  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported SRAM between instruction fetch and data access.
// Data wins conflicts until fetch has lost IM_MAX_WAIT conflicts in a row,
// then fetch wins the next conflict. Read responses return one cycle after
// the grant; each port keeps its last delivered read word.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IM_MAX_WAIT = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                im_req_i,
  input  logic [ADDR_W-1:0]   im_addr_i,
  output logic                im_gnt_o,
  output logic                im_rvalid_o,
  output logic [DATA_W-1:0]   im_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_en_o,
  output logic [DATA_W/8-1:0] mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [CNT_W-1:0]    conflict_cnt_o
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  mem_owner_t          resp_owner_q, resp_owner_d;
  logic [DATA_W-1:0]   im_hold_q, im_hold_d;
  logic [DATA_W-1:0]   dm_hold_q, dm_hold_d;
  logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;
  logic                conflict;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign conflict = im_req_i & dm_req_i;

  // Grant selection and priority/wait-counter next state.
  always_comb begin
    im_gnt_o   = 1'b0;
    dm_gnt_o   = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (conflict) begin
      if (state_q == ARB_IM_PRIO) im_gnt_o = 1'b1;
      else                        dm_gnt_o = 1'b1;
    end else begin
      im_gnt_o = im_req_i;
      dm_gnt_o = dm_req_i;
    end
    if (im_gnt_o) begin
      wait_cnt_d = '0;
      state_d    = ARB_DM_PRIO;
    end else if (conflict && state_q == ARB_DM_PRIO) begin
      // wait_cnt never passes IM_MAX_WAIT: the state flips when it gets there.
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_d == WAIT_W'(IM_MAX_WAIT)) state_d = ARB_IM_PRIO;
    end
  end

  // Route the granted port onto the memory interface; idle drives zeros.
  always_comb begin
    mem_en_o    = im_gnt_o | dm_gnt_o;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (dm_gnt_o) begin
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
      mem_we_o    = dm_we_i ? dm_be_i : BE_W'(0);
    end else if (im_gnt_o) begin
      mem_addr_o  = im_addr_i;
    end
  end

  // Response ownership, held read data and conflict counter next state.
  always_comb begin
    resp_owner_d   = OWN_NONE;
    im_hold_d      = im_hold_q;
    dm_hold_d      = dm_hold_q;
    conflict_cnt_d = conflict_cnt_q;
    if (im_gnt_o)                  resp_owner_d = OWN_IM;
    else if (dm_gnt_o && !dm_we_i) resp_owner_d = OWN_DM;
    if (resp_owner_q == OWN_IM) im_hold_d = mem_rdata_i;
    if (resp_owner_q == OWN_DM) dm_hold_d = mem_rdata_i;
    if (conflict) conflict_cnt_d = sat_inc(conflict_cnt_q);
  end

  // State registers; reset also discards a response granted during reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ARB_DM_PRIO;
      wait_cnt_q     <= '0;
      resp_owner_q   <= OWN_NONE;
      im_hold_q      <= '0;
      dm_hold_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      resp_owner_q   <= resp_owner_d;
      im_hold_q      <= im_hold_d;
      dm_hold_q      <= dm_hold_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign im_rvalid_o    = (resp_owner_q == OWN_IM);
  assign dm_rvalid_o    = (resp_owner_q == OWN_DM);
  assign im_rdata_o     = im_rvalid_o ? mem_rdata_i : im_hold_q;
  assign dm_rdata_o     = dm_rvalid_o ? mem_rdata_i : dm_hold_q;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule
